softmax_sequencer: RTL and testbench

SOFTMAX_SEQUENCER -- requirements
Module: softmax_sequencer

---
 rtl/softmax_sequencer_pkg.sv | 27 ++
 rtl/softmax_sequencer_frame_buffer.sv | 30 +++
 rtl/softmax_sequencer.sv | 145 ++++++++++++++
 tb/tb_softmax_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_sequencer_pkg.sv
// Shared types and sizing helpers for the softmax sequencer.
package softmax_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    START    = 3'd2,
    STREAM   = 3'd3,
    WAIT_SUM = 3'd4,
    HOLD     = 3'd5
  } state_e;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;
  // Timeout counter must be able to hold the value TIMEOUT_CYCLES itself
  localparam int TMO_CNT_W = $clog2(TIMEOUT_CYCLES_DEFAULT + 1);

  // Width of a timeout counter able to represent 0..cycles
  function automatic int tmo_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  // Width of an index addressing 0..n-1
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/softmax_sequencer_frame_buffer.sv
// Frame buffer: one synchronous write port, one combinational read port.
module sequencer_frame_buffer
  import softmax_sequencer_pkg::*;
#(
  parameter int DATA_SIZE      = 32,
  parameter int NUMBER_OF_DATA = 10,
  parameter int ADDR_W         = idx_width(NUMBER_OF_DATA)
) (
  input  logic                 clock_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  input  logic [DATA_SIZE-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]    rd_addr_i,
  output logic [DATA_SIZE-1:0] rd_data_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUMBER_OF_DATA - 1);

  logic [DATA_SIZE-1:0] mem_q [NUMBER_OF_DATA];

  // Store accepted words; contents are deliberately not reset
  always_ff @(posedge clock_i) begin
    if (wr_en_i && (wr_addr_i <= LAST_ADDR)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = (rd_addr_i <= LAST_ADDR) ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/softmax_sequencer.sv
// Softmax sequencer: collects a frame of words, streams it to the downscale
// stage behind a start pulse, then waits (bounded) for the adder's sum and
// holds it until the consumer takes it.
module softmax_sequencer
  import softmax_sequencer_pkg::*;
#(
  parameter int DATA_SIZE      = 32,
  parameter int NUMBER_OF_DATA = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 src_valid_i,
  input  logic [DATA_SIZE-1:0] src_data_i,
  output logic                 src_ready_o,
  output logic                 pipe_start_o,
  output logic [DATA_SIZE-1:0] pipe_data_o,
  output logic                 pipe_data_valid_o,
  input  logic [DATA_SIZE-1:0] sum_i,
  input  logic                 sum_valid_i,
  output logic [DATA_SIZE-1:0] result_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [15:0]          frame_cnt_o
);

  localparam int IW = idx_width(NUMBER_OF_DATA);
  localparam int TW = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUMBER_OF_DATA - 1);
  // Last counter value seen in WAIT_SUM before the count reaches TIMEOUT_CYCLES
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        wr_idx_q, rd_idx_q;
  logic [TW-1:0]        tmo_q;
  logic                 src_ready_q, pipe_start_q, pipe_valid_q;
  logic                 result_valid_q, busy_q, timeout_q;
  logic [DATA_SIZE-1:0] result_q, rd_data;
  logic [15:0]          frame_cnt_q;
  logic                 xfer, tmo_expire, hold_done;

  // A word moves only when we advertise ready; ready is a registered state decode
  assign xfer       = src_valid_i & src_ready_q;
  // The sum wins over an expiring timeout on the same cycle
  assign tmo_expire = (state_q == WAIT_SUM) && !sum_valid_i && (tmo_q == TMO_LAST);
  assign hold_done  = (state_q == HOLD) && result_ready_i;

  sequencer_frame_buffer #(
    .DATA_SIZE      (DATA_SIZE),
    .NUMBER_OF_DATA (NUMBER_OF_DATA),
    .ADDR_W         (IW)
  ) u_buf (
    .clock_i   (clock_i),
    .wr_en_i   (xfer),
    .wr_addr_i (wr_idx_q),
    .wr_data_i (src_data_i),
    .rd_addr_i (rd_idx_q),
    .rd_data_o (rd_data)
  );

  // Next-state selection for the frame sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (xfer) state_d = COLLECT;
      COLLECT:  if (xfer && (wr_idx_q == LAST_IDX)) state_d = START;
      START:    state_d = STREAM;
      STREAM:   if (rd_idx_q == LAST_IDX) state_d = WAIT_SUM;
      WAIT_SUM: begin
        if (sum_valid_i)     state_d = HOLD;
        else if (tmo_expire) state_d = IDLE;
      end
      HOLD:     if (result_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State, indices, timeout counter and registered outputs
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      wr_idx_q       <= '0;
      rd_idx_q       <= '0;
      tmo_q          <= '0;
      src_ready_q    <= 1'b1;
      pipe_start_q   <= 1'b0;
      pipe_valid_q   <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      timeout_q      <= 1'b0;
      result_q       <= '0;
      frame_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      src_ready_q    <= (state_d == IDLE) || (state_d == COLLECT);
      pipe_start_q   <= (state_d == START);
      pipe_valid_q   <= (state_d == STREAM);
      result_valid_q <= (state_d == HOLD);
      busy_q         <= (state_d != IDLE);

      if (xfer) begin
        wr_idx_q <= (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + 1'b1;
      end

      if (state_q == STREAM) begin
        rd_idx_q <= (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + 1'b1;
      end

      // Counter is zero on every WAIT_SUM entry because it idles at zero elsewhere
      if (state_q != WAIT_SUM) begin
        tmo_q <= '0;
      end else if (!sum_valid_i && (tmo_q != TMO_LAST)) begin
        tmo_q <= tmo_q + 1'b1;
      end

      if ((state_q == WAIT_SUM) && sum_valid_i) begin
        result_q <= sum_i;
      end

      // Sticky until the next frame's first word is accepted
      if (tmo_expire) begin
        timeout_q <= 1'b1;
      end else if ((state_q == IDLE) && xfer) begin
        timeout_q <= 1'b0;
      end

      if (hold_done) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign src_ready_o       = src_ready_q;
  assign pipe_start_o      = pipe_start_q;
  assign pipe_data_valid_o = pipe_valid_q;
  assign pipe_data_o       = pipe_valid_q ? rd_data : '0;
  assign result_o          = result_q;
  assign result_valid_o    = result_valid_q;
  assign busy_o            = busy_q;
  assign timeout_o         = timeout_q;
  assign frame_cnt_o       = frame_cnt_q;

endmodule

// File: tb/tb_softmax_sequencer.sv
// Directed and randomized bench for softmax_sequencer with a frame-level model.
module tb_softmax_sequencer;

  localparam int DS = 32;
  localparam int N  = 10;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          src_valid_i;
  logic [DS-1:0] src_data_i;
  logic          src_ready_o;
  logic          pipe_start_o;
  logic [DS-1:0] pipe_data_o;
  logic          pipe_data_valid_o;
  logic [DS-1:0] sum_i;
  logic          sum_valid_i;
  logic [DS-1:0] result_o;
  logic          result_valid_o;
  logic          result_ready_i;
  logic          busy_o;
  logic          timeout_o;
  logic [15:0]   frame_cnt_o;

  int            pass_cnt  = 0;
  int            fail_cnt  = 0;
  int            total_cnt = 0;
  int            cycle     = 0;
  logic [DS-1:0] words [N];
  logic [15:0]   exp_frames;
  logic          exp_timeout;

  always #5 clk = ~clk;

  softmax_sequencer #(
    .DATA_SIZE      (DS),
    .NUMBER_OF_DATA (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock_i           (clk),
    .reset_i           (reset_i),
    .src_valid_i       (src_valid_i),
    .src_data_i        (src_data_i),
    .src_ready_o       (src_ready_o),
    .pipe_start_o      (pipe_start_o),
    .pipe_data_o       (pipe_data_o),
    .pipe_data_valid_o (pipe_data_valid_o),
    .sum_i             (sum_i),
    .sum_valid_i       (sum_valid_i),
    .result_o          (result_o),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .busy_o            (busy_o),
    .timeout_o         (timeout_o),
    .frame_cnt_o       (frame_cnt_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [DS-1:0] obs, input logic [DS-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_src_ready"},   src_ready_o,       1'b1);
    check1({tag, "_pipe_start"},  pipe_start_o,      1'b0);
    check1({tag, "_pipe_valid"},  pipe_data_valid_o, 1'b0);
    checkw({tag, "_pipe_data"},   pipe_data_o,       '0);
    checkw({tag, "_result"},      result_o,          '0);
    check1({tag, "_result_vld"},  result_valid_o,    1'b0);
    check1({tag, "_busy"},        busy_o,            1'b0);
    check1({tag, "_timeout"},     timeout_o,         1'b0);
    checkw({tag, "_frame_cnt"},   DS'(frame_cnt_o),  '0);
  endtask

  // One frame: collect, stream, then either a sum after sum_delay WAIT_SUM
  // cycles (held for `hold` cycles), a timeout (sum_delay < 0), or a reset
  // during STREAM at position abort_at.
  task automatic run_frame(input bit seq, input bit gapped, input int abort_at,
                           input int sum_delay, input int hold,
                           input logic [DS-1:0] fixed_sum, input bit use_fixed);
    logic [DS-1:0] exp_sum;
    int            c0;
    int            lat_exp;
    exp_sum = '0;
    c0      = 0;
    for (int i = 0; i < N; i++) begin
      words[i] = seq ? DS'(i + 1) : DS'($urandom);
      exp_sum  = exp_sum + words[i];
    end
    if (use_fixed) exp_sum = fixed_sum;

    for (int i = 0; i < N; i++) begin
      if (gapped && (i > 0)) begin
        src_valid_i = 1'b0;
        src_data_i  = DS'($urandom);
        step();
        check1("stall_ready", src_ready_o, 1'b1);
        check1("stall_no_start", pipe_start_o, 1'b0);
      end
      src_valid_i = 1'b1;
      src_data_i  = words[i];
      if (i == 0) begin
        c0 = cycle;
        check1("timeout_before_first", timeout_o, exp_timeout);
      end else begin
        check1("collect_ready", src_ready_o, 1'b1);
      end
      step();
      if (i == 0) begin
        exp_timeout = 1'b0;
        check1("timeout_cleared", timeout_o, exp_timeout);
        check1("busy_collect", busy_o, 1'b1);
      end
    end

    // Inputs that must be ignored while not collecting / not waiting for a sum
    src_data_i  = DS'($urandom);
    sum_valid_i = 1'b1;
    sum_i       = DS'($urandom);
    check1("start_pulse", pipe_start_o, 1'b1);
    check1("ready_drop", src_ready_o, 1'b0);
    check1("start_no_valid", pipe_data_valid_o, 1'b0);
    checkw("start_data_zero", pipe_data_o, '0);
    step();

    for (int k = 0; k < N; k++) begin
      check1("stream_valid", pipe_data_valid_o, 1'b1);
      checkw("stream_data", pipe_data_o, words[k]);
      if (k == 0) check1("stream_start_low", pipe_start_o, 1'b0);
      if (k == abort_at) begin
        src_valid_i = 1'b0;
        sum_valid_i = 1'b0;
        reset_i     = 1'b1;
        step();
        reset_i     = 1'b0;
        exp_frames  = '0;
        exp_timeout = 1'b0;
        check_reset_outputs("abort");
        return;
      end
      step();
    end

    src_valid_i = 1'b0;
    sum_valid_i = 1'b0;
    lat_exp = 2 * N + 2 + (gapped ? N - 1 : 0);
    checkw("wait_latency", DS'(cycle - c0 + 1), DS'(lat_exp));
    check1("wait_no_valid", pipe_data_valid_o, 1'b0);
    checkw("wait_data_zero", pipe_data_o, '0);
    check1("wait_busy", busy_o, 1'b1);

    if (sum_delay < 0) begin
      for (int d = 0; d < T; d++) begin
        check1("wait_no_timeout", timeout_o, 1'b0);
        check1("wait_still_busy", busy_o, 1'b1);
        step();
      end
      exp_timeout = 1'b1;
      check1("timeout_set", timeout_o, 1'b1);
      check1("timeout_idle", busy_o, 1'b0);
      check1("timeout_ready", src_ready_o, 1'b1);
      check1("timeout_no_result", result_valid_o, 1'b0);
      checkw("timeout_frames", DS'(frame_cnt_o), DS'(exp_frames));
      return;
    end

    for (int d = 0; d < sum_delay; d++) begin
      check1("wait_no_result", result_valid_o, 1'b0);
      step();
    end
    sum_valid_i = 1'b1;
    sum_i       = exp_sum;
    step();
    sum_valid_i = 1'b0;
    sum_i       = ~exp_sum;
    for (int h = 0; h < hold; h++) begin
      result_ready_i = 1'b0;
      check1("hold_valid", result_valid_o, 1'b1);
      checkw("hold_data", result_o, exp_sum);
      step();
    end
    result_ready_i = 1'b1;
    check1("hold_last_valid", result_valid_o, 1'b1);
    checkw("hold_last_data", result_o, exp_sum);
    check1("hold_no_timeout", timeout_o, 1'b0);
    step();
    result_ready_i = 1'b0;
    exp_frames     = exp_frames + 16'd1;
    check1("done_idle", busy_o, 1'b0);
    check1("done_result_vld", result_valid_o, 1'b0);
    check1("done_ready", src_ready_o, 1'b1);
    checkw("frame_cnt", DS'(frame_cnt_o), DS'(exp_frames));
  endtask

  initial begin
    reset_i        = 1'b1;
    src_valid_i    = 1'b0;
    src_data_i     = '0;
    sum_i          = '0;
    sum_valid_i    = 1'b0;
    result_ready_i = 1'b0;
    exp_frames     = '0;
    exp_timeout    = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    reset_i = 1'b0;
    step();

    // Words 1..10 back-to-back, sum 0x1234 five cycles into WAIT_SUM, 3-cycle stall
    run_frame(1'b1, 1'b0, -1, 5, 3, 32'h0000_1234, 1'b1);
    // Same words with upstream gaps
    run_frame(1'b1, 1'b1, -1, int'($urandom_range(0, T - 2)), int'($urandom_range(0, 3)), '0, 1'b0);
    // No sum: timeout
    run_frame(1'b0, 1'b0, -1, -1, 0, '0, 1'b0);
    step();
    check1("timeout_sticky", timeout_o, 1'b1);
    // Sum on the exact expiry cycle
    run_frame(1'b0, 1'b0, -1, T - 1, 1, '0, 1'b0);
    // Reset in STREAM at rd_idx = 4, then a normal frame
    run_frame(1'b0, 1'b0, 4, 0, 0, '0, 1'b0);
    run_frame(1'b0, 1'b0, -1, 2, 1, '0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      run_frame(1'b0, 1'($urandom_range(0, 1)), -1, int'($urandom_range(0, T - 1)),
                int'($urandom_range(0, 2)), '0, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
